// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The FAULT state only exists when FETCH_MISALIGN_CHECK_EN is defined.
package fetch_pkg;

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {StReq, StWait, StDrop, StFault} fetch_state_e;
`else
    typedef enum logic [1:0] {StReq, StWait, StDrop} fetch_state_e;
`endif

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port: valid/ready request channel, valid-only response channel.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, one request in flight, NOP-filled output slot.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirects into a sticky fault state.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    fetch_unit_if.master       imem,
    output logic [31:0]        instruction,
    output logic [31:0]        outPC,
    output logic               fetch_valid,
    output logic               fault
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  target;
    logic         accept;
    logic         take_redirect;

    // Only request when the output slot is empty or drains this cycle.
    assign imem.imem_req_valid = (state == StReq) && (!fetch_valid || !stall);
    assign imem.imem_req_addr  = pc;
    assign accept              = imem.imem_req_valid && imem.imem_req_ready;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic raise_fault;
    assign target        = redirect_pc;
    assign raise_fault   = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign take_redirect = redirect_valid && !raise_fault && (state != StFault);
`else
    assign target        = redirect_pc & ~32'h3;
    assign take_redirect = redirect_valid;
    assign fault         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StReq;
            pc          <= RESET_PC;
            fetch_valid <= 1'b0;
            instruction <= NOP_INSN;
            outPC       <= RESET_PC;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault       <= 1'b0;
`endif
        end else begin
            if (fetch_valid && !stall) begin
                fetch_valid <= 1'b0;
                instruction <= NOP_INSN;
            end

            if (take_redirect) begin
                pc          <= target;
                fetch_valid <= 1'b0;
                instruction <= NOP_INSN;
                unique case (state)
                    StReq:  state <= accept ? StDrop : StReq;
                    // A response landing with the redirect retires the outstanding request.
                    StWait: state <= imem.imem_rsp_valid ? StReq : StDrop;
                    StDrop: state <= imem.imem_rsp_valid ? StReq : StDrop;
                    default: state <= state;
                endcase
`ifdef FETCH_MISALIGN_CHECK_EN
            end else if (raise_fault) begin
                fault       <= 1'b1;
                fetch_valid <= 1'b0;
                instruction <= NOP_INSN;
                state       <= StFault;
`endif
            end else begin
                unique case (state)
                    StReq: begin
                        if (accept) state <= StWait;
                    end
                    StWait: begin
                        if (imem.imem_rsp_valid) begin
                            instruction <= imem.imem_rsp_data;
                            outPC       <= pc;
                            fetch_valid <= 1'b1;
                            pc          <= pc + PC_STEP;
                            state       <= StReq;
                        end
                    end
                    StDrop: begin
                        if (imem.imem_rsp_valid) state <= StReq;
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected deliveries,
// a negedge monitor pops and compares each new fetch_valid slot.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] instruction, out_pc, instruction2, out_pc2;
    logic        fetch_valid, fault, fetch_valid2, fault2;

    fetch_unit_if imem ();
    fetch_unit_if imem2 ();

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem          (imem),
        .instruction   (instruction),
        .outPC         (out_pc),
        .fetch_valid   (fetch_valid),
        .fault         (fault)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk           (clk),
        .reset         (reset),
        .stall         (1'b0),
        .redirect_valid(1'b0),
        .redirect_pc   (32'h0),
        .imem          (imem2),
        .instruction   (instruction2),
        .outPC         (out_pc2),
        .fetch_valid   (fetch_valid2),
        .fault         (fault2)
    );

    always #5 clk = ~clk;

    // Memory models: always ready, response mem_lat cycles after accept, data = A000_0000 + addr.
    int unsigned mem_lat = 1;
    int unsigned cnt = 0, cnt2 = 0;
    logic [31:0] lat_addr = 32'h0, lat_addr2 = 32'h0;

    always @(posedge clk) begin
        if (reset) cnt <= 0;
        else if (imem.imem_req_valid && imem.imem_req_ready) begin
            cnt      <= mem_lat;
            lat_addr <= imem.imem_req_addr;
        end else if (cnt != 0) cnt <= cnt - 1;
    end
    assign imem.imem_req_ready = 1'b1;
    assign imem.imem_rsp_valid = (cnt == 1);
    assign imem.imem_rsp_data  = 32'hA000_0000 + lat_addr;

    always @(posedge clk) begin
        if (reset) cnt2 <= 0;
        else if (imem2.imem_req_valid && imem2.imem_req_ready) begin
            cnt2      <= 1;
            lat_addr2 <= imem2.imem_req_addr;
        end else if (cnt2 != 0) cnt2 <= cnt2 - 1;
    end
    assign imem2.imem_req_ready = 1'b1;
    assign imem2.imem_rsp_valid = (cnt2 == 1);
    assign imem2.imem_rsp_data  = 32'hA000_0000 + lat_addr2;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    bit          strict = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Monitor: a slot is new unless it was held by stall in the previous cycle.
    logic        prev_fv = 1'b0, prev_stall = 1'b0;
    logic [31:0] mon_exp;
    always @(negedge clk) begin
        if (reset) begin
            prev_fv    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (fetch_valid && !(prev_fv && prev_stall)) begin
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    check("deliver_pc", out_pc, mon_exp);
                    check("deliver_insn", instruction, 32'hA000_0000 + mon_exp);
                end else if (strict) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_delivery: got pc %h, expected none", out_pc);
                end
            end
            if (!fetch_valid) check("nop_fill", instruction, NOP_INSN);
            prev_fv    = fetch_valid;
            prev_stall = stall;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int unsigned lat);
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        mem_lat        = lat;
        exp_q.delete();
        strict         = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_empty(input string name, input int unsigned budget);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            next_cycle();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d deliveries missing, expected 0", name, exp_q.size());
        end
        strict = 1'b0;
    endtask

    task automatic wait_req(input string name, input int unsigned budget);
        int unsigned n = 0;
        while (!imem.imem_req_valid && n < budget) begin
            next_cycle();
            n++;
        end
        check_bit(name, imem.imem_req_valid, 1'b1);
    endtask

    initial begin
        // Sequential fetch with zero-wait memory, then a 5-cycle stall at PC 8.
        do_reset(1);
        check_bit("reset_fv", fetch_valid, 1'b0);
        check("reset_insn", instruction, NOP_INSN);
        check("reset_outpc", out_pc, 32'h0);
        check_bit("reset_fault", fault, 1'b0);
        check_bit("reset_req_valid", imem.imem_req_valid, 1'b1);
        check("reset_req_addr", imem.imem_req_addr, 32'h0);
        check("wrap_first_addr", imem2.imem_req_addr, 32'hFFFF_FFFC);
        check_bit("wrap_fault", fault2, 1'b0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        next_cycle();
        check_bit("seq_c1_fv", fetch_valid, 1'b0);
        next_cycle();
        check_bit("seq_c2_fv", fetch_valid, 1'b1);
        check("seq_c2_req_addr", imem.imem_req_addr, 32'h4);
        check_bit("wrap_fv", fetch_valid2, 1'b1);
        check("wrap_outpc", out_pc2, 32'hFFFF_FFFC);
        check("wrap_insn", instruction2, 32'h9FFF_FFFC);
        check("wrap_second_addr", imem2.imem_req_addr, 32'h0);
        next_cycle();
        check_bit("seq_c3_fv", fetch_valid, 1'b0);
        next_cycle();
        check_bit("seq_c4_fv", fetch_valid, 1'b1);
        check("seq_c4_outpc", out_pc, 32'h4);
        next_cycle();
        check_bit("seq_c5_fv", fetch_valid, 1'b0);
        next_cycle();
        check_bit("seq_c6_fv", fetch_valid, 1'b1);
        check("seq_c6_outpc", out_pc, 32'h8);
        stall = 1'b1;
        #1;
        check_bit("stall_req_valid", imem.imem_req_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            check_bit("stall_hold_fv", fetch_valid, 1'b1);
            check("stall_hold_outpc", out_pc, 32'h8);
            check("stall_hold_insn", instruction, 32'hA000_0008);
            check_bit("stall_hold_req", imem.imem_req_valid, 1'b0);
        end
        next_cycle();
        stall = 1'b0;
        #1;
        check_bit("resume_req_valid", imem.imem_req_valid, 1'b1);
        check("resume_req_addr", imem.imem_req_addr, 32'hC);
        wait_empty("resume_delivery", 10);

        // Redirect while waiting on the response for PC 4 (3-cycle memory).
        do_reset(3);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h100);
        repeat (4) next_cycle();
        check_bit("redir_pre_fv", fetch_valid, 1'b1);
        check("redir_pre_outpc", out_pc, 32'h0);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        next_cycle();
        redirect_valid = 1'b0;
        check_bit("redir_flush_fv", fetch_valid, 1'b0);
        check_bit("redir_drop_req", imem.imem_req_valid, 1'b0);
        wait_req("redir_req_valid", 10);
        check("redir_req_addr", imem.imem_req_addr, 32'h100);
        wait_empty("redir_delivery", 12);

        // Redirect coincident with a response while stalled: no DROP, immediate request.
        do_reset(1);
        exp_q.push_back(32'h200);
        next_cycle();
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        check_bit("coinc_fv", fetch_valid, 1'b0);
        check_bit("coinc_req_valid", imem.imem_req_valid, 1'b1);
        check("coinc_req_addr", imem.imem_req_addr, 32'h200);
        stall = 1'b0;
        wait_empty("coinc_delivery", 10);

        // Misaligned redirect.
        do_reset(1);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
`ifndef FETCH_MISALIGN_CHECK_EN
        exp_q.push_back(32'h100);
`endif
        next_cycle();
        redirect_valid = 1'b0;
        check_bit("misalign_fv", fetch_valid, 1'b0);
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            check_bit("misalign_fault", fault, 1'b1);
            check_bit("misalign_no_req", imem.imem_req_valid, 1'b0);
            next_cycle();
        end
`else
        check_bit("misalign_fault", fault, 1'b0);
        check_bit("misalign_req_valid", imem.imem_req_valid, 1'b1);
        check("misalign_req_addr", imem.imem_req_addr, 32'h100);
        wait_empty("misalign_delivery", 10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
